// File: rtl/json_obj_monitor.sv
// rtl/json_obj_monitor.sv - completion/abort statistics for the JSON object recogniser
// Optional per-object history FIFO is built only when JSON_MON_HIST_EN is defined.
module json_obj_monitor #(
   parameter int HIST_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       status,
   input  logic [7:0]       cur_num,
   input  logic [7:0]       max_num,
   input  logic             clr,
   output logic             obj_done,
   output logic [CNT_W-1:0] obj_cnt,
   output logic [CNT_W-1:0] abort_cnt,
   output logic [CNT_W-1:0] pair_total,
   output logic [7:0]       peak_num,
   output logic [7:0]       last_max,
   output logic             status_err,
   output logic             hist_valid,
   input  logic             hist_ready,
   output logic [7:0]       hist_data,
   output logic             hist_ovf
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [9:0]     prev_status;
   logic           done_evt;
   logic           abort_evt;
   logic           not_onehot;
   logic [CNT_W:0] pair_sum;

   // A drop to S0 straight out of S9 is trailing junk, not an abort.
   assign done_evt   = status[9] & ~prev_status[9];
   assign abort_evt  = status[0] & ~prev_status[0] & ~prev_status[9];
   assign not_onehot = (status == 10'd0) || ((status & (status - 10'd1)) != 10'd0);
   assign pair_sum   = {1'b0, pair_total} + (CNT_W+1)'(cur_num);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_status <= 10'b0000000001;
         obj_done    <= 1'b0;
         obj_cnt     <= '0;
         abort_cnt   <= '0;
         pair_total  <= '0;
         peak_num    <= 8'd0;
         last_max    <= 8'd0;
         status_err  <= 1'b0;
      end else begin
         prev_status <= status;
         if (clr) begin
            obj_done   <= 1'b0;
            obj_cnt    <= '0;
            abort_cnt  <= '0;
            pair_total <= '0;
            peak_num   <= 8'd0;
            last_max   <= 8'd0;
            status_err <= 1'b0;
         end else begin
            obj_done <= done_evt;
            if (done_evt) begin
               if (obj_cnt != CNT_MAX)
                  obj_cnt <= obj_cnt + CNT_W'(1);
               pair_total <= pair_sum[CNT_W] ? CNT_MAX : pair_sum[CNT_W-1:0];
               if (cur_num > peak_num)
                  peak_num <= cur_num;
               last_max <= max_num;
            end
            if (abort_evt && (abort_cnt != CNT_MAX))
               abort_cnt <= abort_cnt + CNT_W'(1);
            if (not_onehot)
               status_err <= 1'b1;
         end
      end
   end

`ifdef JSON_MON_HIST_EN
   localparam int          AW       = $clog2(HIST_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(HIST_DEPTH);

   logic [7:0]    mem [HIST_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill;
   logic          push;
   logic          pop;
   logic          full;
   logic          do_push;

   assign push       = done_evt & ~clr;
   assign pop        = hist_valid & hist_ready;
   assign full       = (fill == FULL_CNT);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push    = push & (~full | pop);
   assign hist_valid = (fill != '0);
   assign hist_data  = hist_valid ? mem[rd_ptr] : 8'd0;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= cur_num;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         hist_ovf <= 1'b0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         hist_ovf <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && full && !pop)
            hist_ovf <= 1'b1;
         case ({do_push, pop})
            2'b10:   fill <= fill + (AW+1)'(1);
            2'b01:   fill <= fill - (AW+1)'(1);
            default: fill <= fill;
         endcase
      end
   end
`else
   logic [1:0] unused_hist;

   assign unused_hist = {hist_ready, HIST_DEPTH[0]};
   assign hist_valid  = 1'b0;
   assign hist_data   = 8'd0;
   assign hist_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_json_obj_monitor.sv
// tb/tb_json_obj_monitor.sv - scoreboard bench for json_obj_monitor (CNT_W=8, HIST_DEPTH=4)
// History checks follow JSON_MON_HIST_EN; with it undefined the hist_* outputs must stay 0.
module tb_json_obj_monitor;
`ifdef JSON_MON_HIST_EN
   localparam bit HIST_ON = 1'b1;
`else
   localparam bit HIST_ON = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] status = 10'b1;
   logic [7:0] cur_num = 8'd0;
   logic [7:0] max_num = 8'd0;
   logic       clr = 1'b0;
   logic       hist_ready = 1'b0;
   logic       obj_done, status_err, hist_valid, hist_ovf;
   logic [7:0] obj_cnt, abort_cnt, pair_total, peak_num, last_max, hist_data;

   json_obj_monitor #(.HIST_DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .status(status), .cur_num(cur_num), .max_num(max_num),
      .clr(clr), .obj_done(obj_done), .obj_cnt(obj_cnt), .abort_cnt(abort_cnt),
      .pair_total(pair_total), .peak_num(peak_num), .last_max(last_max),
      .status_err(status_err), .hist_valid(hist_valid), .hist_ready(hist_ready),
      .hist_data(hist_data), .hist_ovf(hist_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] cnt;
      logic [7:0] pair;
      logic [7:0] peak;
      logic [7:0] last;
   } exp_t;

   exp_t       oexp[$];
   logic [7:0] hexp[$];
   logic [7:0] mf[$];
   int         n_cmp = 0;
   int         n_fail = 0;

   logic [9:0] m_prev = 10'b1;
   int         m_cnt = 0, m_abort = 0, m_pair = 0, m_peak = 0, m_last = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] st(input int k);
      logic [9:0] one;
      one = 10'b1;
      return one << k;
   endfunction

   task automatic model_clear();
      m_cnt = 0; m_abort = 0; m_pair = 0; m_peak = 0; m_last = 0;
      mf.delete();
   endtask

   // Drive one cycle of inputs, predict the edge, queue expectations for the monitor.
   task automatic drive(input logic [9:0] s, input logic [7:0] cn, input logic [7:0] mx, input logic c);
      logic done, ab, pop;
      exp_t e;
      status = s; cur_num = cn; max_num = mx; clr = c;
      done = s[9] & ~m_prev[9];
      ab   = s[0] & ~m_prev[0] & ~m_prev[9];
      pop  = HIST_ON && (mf.size() > 0) && hist_ready && !c;
      if (pop) hexp.push_back(mf[0]);
      @(posedge clk); #1;
      m_prev = s;
      if (c) begin
         model_clear();
      end else begin
         if (pop) void'(mf.pop_front());
         if (done) begin
            if (m_cnt != 255) m_cnt++;
            m_pair = (m_pair + cn > 255) ? 255 : m_pair + cn;
            if (cn > m_peak) m_peak = cn;
            m_last = mx;
            if (HIST_ON && mf.size() < DEPTH) mf.push_back(cn);
            e.cnt = 8'(m_cnt); e.pair = 8'(m_pair); e.peak = 8'(m_peak); e.last = 8'(m_last);
            oexp.push_back(e);
         end
         if (ab && m_abort != 255) m_abort++;
      end
   endtask

   task automatic obj(input logic [7:0] cn, input logic [7:0] mx);
      drive(st(9), cn, mx, 1'b0);
      drive(st(0), 8'd0, 8'd0, 1'b0);
   endtask

   task automatic do_clr();
      drive(st(0), 8'd0, 8'd0, 1'b1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_obj_cnt"}, obj_cnt, 0);
      chk({tag, "_abort_cnt"}, abort_cnt, 0);
      chk({tag, "_pair_total"}, pair_total, 0);
      chk({tag, "_peak_num"}, peak_num, 0);
      chk({tag, "_last_max"}, last_max, 0);
      chk({tag, "_obj_done"}, obj_done, 0);
      chk({tag, "_status_err"}, status_err, 0);
      chk({tag, "_hist_valid"}, hist_valid, 0);
      chk({tag, "_hist_data"}, hist_data, 0);
      chk({tag, "_hist_ovf"}, hist_ovf, 0);
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (!reset) begin
         if (obj_done) begin
            n_cmp++;
            if (oexp.size() == 0) begin
               n_fail++;
               $display("FAIL obj_done_spurious: got 1 expected 0");
            end else begin
               exp_t e;
               e = oexp.pop_front();
               if (obj_cnt !== e.cnt || pair_total !== e.pair || peak_num !== e.peak || last_max !== e.last) begin
                  n_fail++;
                  $display("FAIL obj_stats: got cnt=%0d pair=%0d peak=%0d last=%0d expected cnt=%0d pair=%0d peak=%0d last=%0d",
                           obj_cnt, pair_total, peak_num, last_max, e.cnt, e.pair, e.peak, e.last);
               end
            end
         end
         if (hist_valid && hist_ready && !clr) begin
            n_cmp++;
            if (hexp.size() == 0) begin
               n_fail++;
               $display("FAIL hist_pop_spurious: got data %0d expected no entry", hist_data);
            end else begin
               logic [7:0] h;
               h = hexp.pop_front();
               if (hist_data !== h) begin
                  n_fail++;
                  $display("FAIL hist_data_pop: got %0d expected %0d", hist_data, h);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      #2;
      chk_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Completion with S9 held for five cycles
      for (int k = 0; k < 9; k++) drive(st(k), 8'd0, 8'd0, 1'b0);
      for (int k = 0; k < 5; k++) drive(st(9), 8'd2, 8'd2, 1'b0);
      chk("t1_obj_cnt", obj_cnt, 1);
      chk("t1_pair_total", pair_total, 2);
      chk("t1_peak_num", peak_num, 2);
      chk("t1_last_max", last_max, 2);
      chk("t1_hist_data", hist_data, HIST_ON ? 2 : 0);
      chk("t1_hist_valid", hist_valid, HIST_ON);

      // Abort versus trailing junk after a closed object
      do_clr();
      drive(st(1), 8'd0, 8'd0, 1'b0);
      drive(st(2), 8'd0, 8'd0, 1'b0);
      drive(st(3), 8'd0, 8'd0, 1'b0);
      drive(st(0), 8'd0, 8'd0, 1'b0);
      chk("t2_abort_cnt", abort_cnt, 1);
      drive(st(1), 8'd0, 8'd0, 1'b0);
      drive(st(9), 8'd0, 8'd0, 1'b0);
      drive(st(0), 8'd0, 8'd0, 1'b0);
      chk("t2_obj_cnt", obj_cnt, 1);
      chk("t2_abort_cnt_after_junk", abort_cnt, 1);

      // Full FIFO with simultaneous push and pop, then empty FIFO with push and ready
      do_clr();
      for (int k = 1; k <= 4; k++) obj(8'(k), 8'(k));
      hist_ready = 1'b1;
      drive(st(9), 8'd9, 8'd9, 1'b0);
      for (int k = 0; k < 4; k++) drive(st(0), 8'd0, 8'd0, 1'b0);
      chk("t3_ovf_push_pop", hist_ovf, 0);
      chk("t3_drained_valid", hist_valid, 0);
      drive(st(9), 8'd7, 8'd7, 1'b0);
      chk("t3_empty_push_valid", hist_valid, HIST_ON);
      chk("t3_empty_push_data", hist_data, HIST_ON ? 7 : 0);
      drive(st(0), 8'd0, 8'd0, 1'b0);
      drive(st(0), 8'd0, 8'd0, 1'b0);

      // Overflow: five objects into a four-entry FIFO
      hist_ready = 1'b0;
      do_clr();
      for (int k = 1; k <= 5; k++) obj(8'(k), 8'(k));
      chk("t4_hist_ovf", hist_ovf, HIST_ON);
      chk("t4_pair_total", pair_total, 15);
      hist_ready = 1'b1;
      for (int k = 0; k < 5; k++) drive(st(0), 8'd0, 8'd0, 1'b0);
      chk("t4_hist_valid_empty", hist_valid, 0);
      chk("t4_hist_data_empty", hist_data, 0);
      chk("t4_hist_ovf_sticky", hist_ovf, HIST_ON);

      // Saturation at CNT_W=8
      do_clr();
      obj(8'd200, 8'd200);
      obj(8'd200, 8'd200);
      chk("t5_pair_total_sat", pair_total, 255);
      chk("t5_peak_num", peak_num, 200);
      chk("t5_obj_cnt", obj_cnt, 2);
      for (int k = 0; k < 260; k++) obj(8'd0, 8'd1);
      chk("t5_obj_cnt_sat", obj_cnt, 255);
      chk("t5_last_max", last_max, 1);

      // clr wins over an event in the same cycle; status_err set and cleared
      hist_ready = 1'b0;
      do_clr();
      drive(st(1), 8'd0, 8'd0, 1'b0);
      drive(st(9), 8'd3, 8'd3, 1'b1);
      drive(st(9), 8'd3, 8'd3, 1'b0);
      drive(st(9), 8'd3, 8'd3, 1'b0);
      chk_zero("t6_clr");
      drive(10'b0000000011, 8'd0, 8'd0, 1'b0);
      chk("t6_status_err_set", status_err, 1);
      drive(st(0), 8'd0, 8'd0, 1'b0);
      chk("t6_status_err_sticky", status_err, 1);
      do_clr();
      chk("t6_status_err_clr", status_err, 0);
      drive(10'd0, 8'd0, 8'd0, 1'b0);
      chk("t6_status_err_zero", status_err, 1);
      do_clr();

      // Asynchronous reset mid-operation
      hist_ready = 1'b1;
      obj(8'd4, 8'd4);
      obj(8'd6, 8'd6);
      hist_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk_zero("t7_reset");
      model_clear();
      hexp.delete();
      m_prev = 10'b1;
      #2;
      reset = 1'b0;
      drive(st(9), 8'd1, 8'd1, 1'b0);
      chk("t7_obj_cnt", obj_cnt, 1);
      drive(st(0), 8'd0, 8'd0, 1'b0);
      drive(st(0), 8'd0, 8'd0, 1'b0);

      chk("end_obj_queue_empty", oexp.size(), 0);
      chk("end_hist_queue_empty", hexp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
